// File: rtl/cosine_pkg.sv
// Shared types and width helpers for the cosine-similarity engine.
package cosine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SQRT,
        DIV,
        DONE
    } cos_state_e;

    function automatic int acc_w(input int elem_w, input int num_elem);
        return 2 * elem_w + $clog2(num_elem);
    endfunction

    function automatic int q_w(input int acc, input int frac);
        return acc + frac;
    endfunction

    function automatic int out_w(input int frac);
        return frac + 2;
    endfunction

    // Saturation constant ONE_FX = 1 << FRAC_W (fixed-point 1.0).
    function automatic int one_fx(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/isqrt_serial.sv
// Bit-serial integer square root: one root bit per cycle, RAD_W/2 cycles per start.
module isqrt_serial #(
    parameter int RAD_W = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [RAD_W-1:0] rad_i,
    output logic             done_o,
    output logic [RAD_W/2-1:0] root_o
);

    localparam int RES_W = RAD_W / 2;
    localparam int REM_W = RES_W + 2;
    localparam int CW    = $clog2(RES_W);

    logic [RAD_W-1:0] rad_q, rad_d, src_rad;
    logic [REM_W-1:0] rem_q, rem_d, src_rem;
    logic [RES_W-1:0] root_q, root_d, src_root;
    logic [REM_W+1:0] rem_sh, trial;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // The start cycle resolves the first root bit straight from rad_i.
    always_comb begin
        src_rad  = start_i ? rad_i : rad_q;
        src_rem  = start_i ? '0 : rem_q;
        src_root = start_i ? '0 : root_q;
        rem_sh   = {src_rem, src_rad[RAD_W-1 -: 2]};
        trial    = {2'b00, src_root, 2'b01};
        rad_d    = {src_rad[RAD_W-3:0], 2'b00};
        if (rem_sh >= trial) begin
            rem_d  = REM_W'(rem_sh - trial);
            root_d = RES_W'({src_root, 1'b1});
        end else begin
            rem_d  = REM_W'(rem_sh);
            root_d = RES_W'({src_root, 1'b0});
        end
    end

    // done_o marks the cycle whose closing edge produces the final bit.
    assign done_o = busy_q && !start_i && (cnt_q == CW'(RES_W - 1));
    assign root_o = root_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i || busy_q) begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(1);
            end else if (cnt_q == CW'(RES_W - 1)) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cosine_sim_engine.sv
// Streaming cosine-similarity engine: accumulate, serial sqrt, restoring divide.
// Build option: COSINE_SIGNED_EN selects two's-complement elements and a signed result.
module cosine_sim_engine
    import cosine_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int NUM_ELEM = 4,
    parameter int FRAC_W   = 7,
    localparam int ACC_W   = acc_w(ELEM_W, NUM_ELEM),
    localparam int Q_W     = q_w(ACC_W, FRAC_W),
    localparam int OUT_W   = out_w(FRAC_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] a_elem,
    input  logic [ELEM_W-1:0] b_elem,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic              res_zero,
    output logic              busy
);

`ifdef COSINE_SIGNED_EN
    localparam int DOT_W = ACC_W + 1;
`else
    localparam int DOT_W = ACC_W;
`endif
    localparam int CE_W  = $clog2(NUM_ELEM);
    localparam int CD_W  = $clog2(Q_W);
    localparam int RAD_W = 2 * ACC_W;
    localparam logic [Q_W-1:0] ONE_FX = Q_W'(one_fx(FRAC_W));

    cos_state_e        state_q;
    logic [DOT_W-1:0]  dot_q;
    logic [ACC_W-1:0]  na2_q, nb2_q;
    logic [CE_W-1:0]   elem_cnt_q;
    logic [CD_W-1:0]   div_cnt_q;
    logic [ACC_W-1:0]  rem_q, rem_d;
    logic [Q_W-1:0]    qr_q, qr_d, q_clamp;
    logic [ACC_W:0]    div_sh;
    logic [OUT_W-1:0]  res_data_q, res_fin;
    logic              res_zero_q;
    logic              sq_start_q, sq_done;
    logic [ACC_W-1:0]  sq_root;
    logic [RAD_W-1:0]  radicand;
    logic [DOT_W-1:0]  a_x, b_x, p_ab, p_aa, p_bb;
    logic [ACC_W-1:0]  dot_mag;
    logic              norm_zero, beat;

`ifdef COSINE_SIGNED_EN
    assign a_x     = {{(DOT_W-ELEM_W){a_elem[ELEM_W-1]}}, a_elem};
    assign b_x     = {{(DOT_W-ELEM_W){b_elem[ELEM_W-1]}}, b_elem};
    assign dot_mag = dot_q[DOT_W-1] ? ACC_W'(-dot_q) : ACC_W'(dot_q);
`else
    assign a_x     = {{(DOT_W-ELEM_W){1'b0}}, a_elem};
    assign b_x     = {{(DOT_W-ELEM_W){1'b0}}, b_elem};
    assign dot_mag = dot_q;
`endif

    // Low bits of the product are sign-agnostic, so one multiplier serves both modes.
    assign p_ab = a_x * b_x;
    assign p_aa = a_x * a_x;
    assign p_bb = b_x * b_x;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign beat      = in_valid && in_ready;
    assign norm_zero = (na2_q == '0) || (nb2_q == '0);
    assign radicand  = {{ACC_W{1'b0}}, na2_q} * {{ACC_W{1'b0}}, nb2_q};

    isqrt_serial #(
        .RAD_W(RAD_W)
    ) u_isqrt (
        .clk    (clk),
        .reset  (reset),
        .start_i(sq_start_q),
        .rad_i  (radicand),
        .done_o (sq_done),
        .root_o (sq_root)
    );

    // Restoring divide step: dividend shifts out of qr_q as quotient bits shift in.
    always_comb begin
        div_sh = {rem_q, qr_q[Q_W-1]};
        if (div_sh >= {1'b0, sq_root}) begin
            rem_d = ACC_W'(div_sh - {1'b0, sq_root});
            qr_d  = {qr_q[Q_W-2:0], 1'b1};
        end else begin
            rem_d = div_sh[ACC_W-1:0];
            qr_d  = {qr_q[Q_W-2:0], 1'b0};
        end
        q_clamp = (qr_d > ONE_FX) ? ONE_FX : qr_d;
`ifdef COSINE_SIGNED_EN
        res_fin = dot_q[DOT_W-1] ? OUT_W'(-q_clamp) : OUT_W'(q_clamp);
`else
        res_fin = OUT_W'(q_clamp);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dot_q      <= '0;
            na2_q      <= '0;
            nb2_q      <= '0;
            elem_cnt_q <= '0;
            div_cnt_q  <= '0;
            rem_q      <= '0;
            qr_q       <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            sq_start_q <= 1'b0;
        end else begin
            sq_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        dot_q      <= p_ab;
                        na2_q      <= ACC_W'(p_aa);
                        nb2_q      <= ACC_W'(p_bb);
                        elem_cnt_q <= CE_W'(1);
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        dot_q <= dot_q + p_ab;
                        na2_q <= na2_q + ACC_W'(p_aa);
                        nb2_q <= nb2_q + ACC_W'(p_bb);
                        if (elem_cnt_q == CE_W'(NUM_ELEM - 1)) begin
                            elem_cnt_q <= '0;
                            sq_start_q <= 1'b1;
                            state_q    <= SQRT;
                        end else begin
                            elem_cnt_q <= elem_cnt_q + CE_W'(1);
                        end
                    end
                end
                SQRT: begin
                    if (sq_done) begin
                        if (norm_zero) begin
                            res_zero_q <= 1'b1;
                            res_data_q <= '0;
                            state_q    <= DONE;
                        end else begin
                            rem_q     <= '0;
                            qr_q      <= {dot_mag, {FRAC_W{1'b0}}};
                            div_cnt_q <= '0;
                            state_q   <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q     <= rem_d;
                    qr_q      <= qr_d;
                    div_cnt_q <= div_cnt_q + CD_W'(1);
                    if (div_cnt_q == CD_W'(Q_W - 1)) begin
                        res_data_q <= res_fin;
                        res_zero_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_data_q <= '0;
                        res_zero_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cosine_sim_engine.md
# cosine_sim_engine

- Parametrised, handshaked cosine-similarity engine: streams NUM_ELEM element pairs (a_i, b_i), accumulates dot product and both squared norms, then runs a multicycle integer square root and a restoring divider.
- Result is cos(A,B) in fixed point with FRAC_W fractional bits.
- Sits between the vector-fetch stage and the result register file.
- Successor to the fixed 4×8-bit microcoded unit: width and depth are generic, I/O is valid/ready, and zero-norm vectors are detected.

## Interface

Parameters:

- ELEM_W, 8: element width in bits.
- NUM_ELEM, 4: elements per vector (≥2).
- FRAC_W, 7: result fractional bits.
- Derived: ACC_W = 2*ELEM_W + $clog2(NUM_ELEM); Q_W = ACC_W + FRAC_W; OUT_W = FRAC_W + 2.

Ports:

- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  element pair valid.
- in_ready  out  1  engine accepts a pair.
- a_elem  in  ELEM_W  element of A.
- b_elem  in  ELEM_W  element of B.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  OUT_W  two's-complement cosine, 1.0 = 2^FRAC_W.
- res_zero  out  1  |A| or |B| is zero; res_data = 0.
- busy  out  1  state ≠ IDLE.

## Operation

- **FSM states**: IDLE, ACCUM, SQRT, DIV, DONE.
- **Beats**:
  - A beat is in_valid && in_ready.
  - in_ready = 1 only in IDLE and ACCUM.
  - The first beat, accepted in IDLE, loads a*b, a*a and b*b into dot/na2/nb2 (no clear cycle) and moves to ACCUM.
  - Each further beat adds to the accumulators.
  - An element counter wraps at NUM_ELEM; the NUM_ELEM-th beat moves to SQRT.
  - in_valid low in ACCUM stalls the FSM with no state change.
- **SQRT**:
  - Computes s = floor(sqrt(na2*nb2)), a 2*ACC_W-bit radicand, bit-serial, one result bit per cycle, exactly ACC_W cycles.
  - If s == 0: res_zero = 1, res_data = 0, go to DONE and skip DIV.
  - Otherwise go to DIV.
- **DIV**:
  - Restoring division of |dot|<<FRAC_W by s, one quotient bit per cycle, exactly Q_W cycles.
  - The quotient is clamped to 2^FRAC_W, since floor in the sqrt can give a result above 1.0.
  - The sign of dot is then applied.
- **DONE**:
  - res_valid = 1; res_data and res_zero are held stable until res_ready.
  - On res_valid && res_ready, go to IDLE.
  - in_ready = 0 throughout, so upstream beats are back-pressured.
- **Unsigned elements**: dot ≥ 0 and res_data[OUT_W-1] = 0.
- **Reset mid-operation**: reset low in any state forces IDLE and discards the partial result; no res_valid follows.

## Timing

- **Reset values**:
  - in_ready = 1.
  - res_valid = 0, res_data = 0, res_zero = 0, busy = 0.
  - All accumulators, the element counter and the datapath registers are 0.
- **Throughput**: one beat per cycle while in ACCUM.
- **Latency, non-zero norms**: res_valid rises ACC_W + Q_W cycles after the clock edge that accepts the last beat. Defaults: 18 + 25 = 43.
- **Latency, zero norm**: ACC_W cycles (default 18).
- **Back-to-back results**: in_ready returns high the cycle after the result handshake. The minimum issue interval is NUM_ELEM + ACC_W + Q_W + 1 cycles.
- **Registered outputs**: res_data and res_zero are registered; res_valid comes directly from the state register.

## Configuration

- Macro: COSINE_SIGNED_EN.
- **Defined**:
  - a_elem and b_elem are two's-complement.
  - dot is signed, ACC_W+1 bits; na2 and nb2 stay unsigned.
  - res_data spans -2^FRAC_W … +2^FRAC_W.
- **Undefined**:
  - Elements are unsigned.
  - dot is unsigned.
  - The sign logic is removed and res_data ∈ [0, 2^FRAC_W].

## Structure

- **Package cosine_pkg**:
  - FSM state enum (cos_state_e).
  - Width-derivation localparam functions (acc_w, q_w, out_w).
  - Saturation constant ONE_FX = 1 << FRAC_W.
- **Sub-module isqrt_serial**:
  - Parametrised by radicand width.
  - Handshake: start/done.
  - Bit-serial, one result bit per cycle.
  - Used for the SQRT state.
- The divider stays inline in the top-level.

## Test plan

- **Basic vector**: A=[1,2,3,4], B=[5,6,7,8], one beat per cycle. Expect dot=70, s=72, res_data=124, res_zero=0, res_valid 43 cycles after the last beat.
- **Identical vectors**: A=B=[3,4,0,0]. Expect res_data=128 (1.0); the clamp is not exceeded.
- **Zero norm**: A=[0,0,0,0], B=[1,1,1,1]. Expect res_zero=1, res_data=0, res_valid 18 cycles after the last beat; DIV never entered.
- **Stalls and back-pressure**:
  - Drop in_valid for 3 cycles mid-vector: the result is identical.
  - Hold res_ready low 10 cycles: res_data stays stable and in_ready stays 0.
  - A second vector presented meanwhile is accepted only after the handshake.
- **Reset mid-operation**: reset during DIV. Expect res_valid=0 and in_ready=1 immediately. The next vector (orthogonal, A=[1,0,0,0], B=[0,1,0,0]) gives res_data=0, res_zero=0.
- **Signed mode** (COSINE_SIGNED_EN): A=[1,0,0,0], B=[-1,0,0,0]. Expect res_data=9'h180 (-1.0).
